image_add_ctrl: RTL and testbench
=================================

# image_add_ctrl

Controller that sequences the pixel-add datapath. On a start pulse it walks both source image memories, address 0 to NPIX-1. It adds each pixel pair and writes the sum to the output memory at the same address, accounting for the memories' read latency. It replaces the free-running address counter with a start/busy/done handshake and a well-defined end-of-frame.

## Interface
- NPIX, 64: pixels per frame; legal range 2..2^AW.
- AW, 6: address width.
- RD_LAT, 1: source memory read latency in cycles; legal range 1..4.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begins a frame when sampled high in IDLE.
- abort  in  1  synchronous; cancels the frame in progress.
- pix_a  in  8  source memory A read data.
- pix_b  in  8  source memory B read data.
- rd_en  out  1  read strobe to both source memories.
- rd_addr  out  AW  shared read address.
- wr_en  out  1  output memory write enable.
- wr_addr  out  AW  output memory write address.
- wr_data  out  8  sum written to output memory.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at end of frame.
- ovf  out  1  sticky; set if any 9-bit sum in the frame exceeded 255.

## Operation
- States:
  - IDLE: start -> READ.
  - READ: issue addresses; after address NPIX-1 -> DRAIN.
  - DRAIN: wait until the last write retires -> DONE.
  - DONE: one cycle -> IDLE.
- abort in READ or DRAIN -> IDLE:
  - in-flight reads are discarded and no wr_en is issued.
  - done does not pulse.
  - ovf holds its value.
- In READ: rd_en=1 and rd_addr increments by 1 each cycle, no gaps.
- Address counter is AW+1 bits internally so NPIX = 2^AW terminates without wrap-around.
- A valid/address delay line of depth RD_LAT tags returning data.
- Sum = pix_a + pix_b, computed at 9 bits; wr_data is the low 8 bits (see Configuration).
- ovf clears on each accepted start.
- start while busy is ignored; start in the DONE cycle is ignored.
- All outputs are registered.

## Timing
- Reset values:
  - state IDLE.
  - rd_en, wr_en, busy, done, ovf all 0.
  - rd_addr, wr_addr, wr_data all 0.
- Cycle 0: start sampled.
- Cycle 1+k: rd_addr=k, rd_en=1, for k=0..NPIX-1.
- Cycle 1+k+RD_LAT: pix_a/pix_b valid for address k.
- Cycle 2+k+RD_LAT: wr_en=1, wr_addr=k, wr_data=sum.
- Cycle NPIX+2+RD_LAT: done=1, busy=0, state back in IDLE on the next cycle.
- Throughput: one pixel per cycle. Total frame length: NPIX+RD_LAT+3 cycles including the start cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). Writes stop; partial output frame contents are undefined.

## Configuration
- SAT_ADD_EN defined:
  - wr_data = 255 when the 9-bit sum > 255, else the sum (saturating).
- SAT_ADD_EN undefined:
  - wr_data = sum mod 256 (wrapping, matching the existing 8-bit adder).
- ovf behaves identically in both builds.

## Structure
- Shared package image_add_pkg holds:
  - PIX_W = 8.
  - State enum (IDLE, READ, DRAIN, DONE).
  - Default NPIX/AW constants.
- Sub-module lat_delay: parameterised valid+address shift register of depth RD_LAT, async active-low reset, synchronous flush driven by abort.

## Test plan
- NPIX=64, RD_LAT=1, A[k]=k, B[k]=2k:
  - writes on cycles 3..66 with wr_data=(3k) mod 256.
  - done on cycle 67, exactly 64 wr_en cycles.
- A=200, B=100 everywhere:
  - SAT_ADD_EN defined -> wr_data=255.
  - SAT_ADD_EN undefined -> wr_data=44.
  - ovf=1 after the first write in both builds.
- RD_LAT=3, NPIX=4:
  - writes on cycles 5..8 at addresses 0..3.
  - done on cycle 9.
- start pulsed again on cycle 10 of a running frame -> ignored: single done, address sequence unbroken.
- abort on cycle 20 -> no wr_en from cycle 21, done never pulses, busy=0 on cycle 21; next start runs a full clean frame.
- reset low on cycle 30 mid-frame -> all outputs 0 in the same cycle; after release, start produces a complete 64-write frame with ovf cleared.

Source files
------------

// File: rtl/image_add_pkg.sv
// image_add_pkg: shared constants, FSM state type and sum helper for the
// image pixel-add controller.
package image_add_pkg;

  // Pixel width of both source images and the output image.
  localparam int PIX_W = 8;

  // Default frame geometry and source memory latency.
  localparam int DEF_NPIX   = 64;
  localparam int DEF_AW     = 6;
  localparam int DEF_RD_LAT = 1;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Clamp a PIX_W+1 bit sum to the largest PIX_W bit value.
  function automatic logic [PIX_W-1:0] clip_sum(input logic [PIX_W:0] sum);
    logic [PIX_W-1:0] res;
    if (sum[PIX_W]) begin
      res = {PIX_W{1'b1}};
    end else begin
      res = sum[PIX_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/image_add_ctrl_lat_delay.sv
// lat_delay: valid + address shift register matching the source memory read
// latency, so each returning pixel pair carries the address it was read from.
// A synchronous flush drops every in-flight tag (used when a frame is aborted).
module lat_delay #(
  parameter int DEPTH = 1,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  output logic          o_valid,
  output logic [AW-1:0] o_addr
);

  logic          r_vld  [DEPTH];
  logic [AW-1:0] r_addr [DEPTH];

  // Shift the read tags one stage per cycle; flush or reset clears all stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i]  <= 1'b0;
        r_addr[i] <= {AW{1'b0}};
      end
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i]  <= 1'b0;
        r_addr[i] <= {AW{1'b0}};
      end
    end else begin
      r_vld[0]  <= i_valid;
      r_addr[0] <= i_addr;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
      end
    end
  end

  assign o_valid = r_vld[DEPTH-1];
  assign o_addr  = r_addr[DEPTH-1];

endmodule

// File: rtl/image_add_ctrl.sv
// image_add_ctrl: sequences the pixel-add datapath for one frame per start.
// Reads address 0..NPIX-1 from both source memories back to back, adds each
// returning pixel pair and writes the sum to the output memory at the same
// address once the read latency has elapsed.
// Build option: define SAT_ADD_EN for a saturating adder; otherwise the sum
// wraps modulo 256. ovf (sticky 9-bit overflow) behaves the same either way.
module image_add_ctrl
  import image_add_pkg::*;
#(
  parameter int NPIX   = DEF_NPIX,
  parameter int AW     = DEF_AW,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PIX_W-1:0] pix_a,
  input  logic [PIX_W-1:0] pix_b,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [PIX_W-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  // The read counter is one bit wider than the address so that a frame of
  // exactly 2^AW pixels reaches its end count without wrapping to zero.
  localparam logic [AW:0]   C_END_CNT   = (AW+1)'(NPIX);
  localparam logic [AW:0]   C_CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] C_LAST_ADDR = AW'(NPIX - 1);

  state_t           r_state;
  logic [AW:0]      r_addr_cnt;
  logic             r_rd_en;
  logic [AW-1:0]    r_rd_addr;
  logic             r_wr_en;
  logic [AW-1:0]    r_wr_addr;
  logic [PIX_W-1:0] r_wr_data;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;

  logic             w_active;
  logic             w_abort;
  logic             w_start_acc;
  logic             w_tag_valid;
  logic [AW-1:0]    w_tag_addr;
  logic             w_fire;
  logic [PIX_W:0]   w_sum;
  logic [PIX_W-1:0] w_data;

  // abort only has meaning while a frame is moving through READ or DRAIN.
  assign w_active    = (r_state == READ) || (r_state == DRAIN);
  assign w_abort     = abort && w_active;
  assign w_start_acc = (r_state == IDLE) && start;

  // Tags the returning read data with its valid bit and address.
  lat_delay #(
    .DEPTH (RD_LAT),
    .AW    (AW)
  ) u_lat_delay (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (w_abort),
    .i_valid (r_rd_en),
    .i_addr  (r_rd_addr),
    .o_valid (w_tag_valid),
    .o_addr  (w_tag_addr)
  );

  // A tagged pixel pair is written unless the frame is being aborted now.
  assign w_fire = w_tag_valid && !w_abort;

  // Full-width sum and the value actually stored for this build.
  always_comb begin
    w_sum = {1'b0, pix_a} + {1'b0, pix_b};
`ifdef SAT_ADD_EN
    w_data = clip_sum(w_sum);
`else
    w_data = w_sum[PIX_W-1:0];
`endif
  end

  // Frame sequencer: read address generation, busy and the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_addr_cnt <= {(AW+1){1'b0}};
      r_rd_en    <= 1'b0;
      r_rd_addr  <= {AW{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= READ;
            r_rd_en    <= 1'b1;
            r_rd_addr  <= {AW{1'b0}};
            r_addr_cnt <= C_CNT_ONE;
            r_busy     <= 1'b1;
          end
        end
        READ: begin
          if (abort) begin
            r_state <= IDLE;
            r_rd_en <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_addr_cnt == C_END_CNT) begin
            // Address NPIX-1 has just been issued.
            r_state <= DRAIN;
            r_rd_en <= 1'b0;
          end else begin
            r_rd_addr  <= r_addr_cnt[AW-1:0];
            r_addr_cnt <= r_addr_cnt + C_CNT_ONE;
          end
        end
        DRAIN: begin
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_wr_en && (r_wr_addr == C_LAST_ADDR)) begin
            // The final write is on the output port this cycle.
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          // start is deliberately not looked at here.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_rd_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Write port and sticky overflow flag driven from the tagged read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= {AW{1'b0}};
      r_wr_data <= {PIX_W{1'b0}};
      r_ovf     <= 1'b0;
    end else begin
      r_wr_en <= w_fire;
      if (w_fire) begin
        r_wr_addr <= w_tag_addr;
        r_wr_data <= w_data;
      end
      if (w_start_acc) begin
        r_ovf <= 1'b0;
      end else if (w_fire && w_sum[PIX_W]) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_image_add_ctrl.sv
// tb_image_add_ctrl: two controller instances (64 pixels / latency 1 and
// 4 pixels / latency 3) driven by directed frames. Expected outputs per cycle
// come from a frame schedule built from the start cycle, frame length and
// memory contents; a few literal values pin that schedule.
module tb_image_add_ctrl;

  localparam int SZ = 1024;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: NPIX=64, AW=6, RD_LAT=1
  logic       start0 = 1'b0, abort0 = 1'b0;
  logic [7:0] p0a, p0b;
  logic       rd_en0, wr_en0, busy0, done0, ovf0;
  logic [5:0] rd_addr0, wr_addr0;
  logic [7:0] wr_data0;
  // Instance 1: NPIX=4, AW=2, RD_LAT=3
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [7:0] p1a [0:2];
  logic [7:0] p1b [0:2];
  logic       rd_en1, wr_en1, busy1, done1, ovf1;
  logic [1:0] rd_addr1, wr_addr1;
  logic [7:0] wr_data1;

  image_add_ctrl #(.NPIX(64), .AW(6), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0),
    .pix_a(p0a), .pix_b(p0b), .rd_en(rd_en0), .rd_addr(rd_addr0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .done(done0), .ovf(ovf0));

  image_add_ctrl #(.NPIX(4), .AW(2), .RD_LAT(3)) dut_small (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .pix_a(p1a[2]), .pix_b(p1b[2]), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .done(done1), .ovf(ovf1));

  // Source memories with RD_LAT register stages on the read data.
  logic [7:0] mem_a [0:1][0:63];
  logic [7:0] mem_b [0:1][0:63];
  always @(posedge clk) begin
    p0a    <= mem_a[0][int'(rd_addr0)];
    p0b    <= mem_b[0][int'(rd_addr0)];
    p1a[0] <= mem_a[1][int'(rd_addr1)];
    p1b[0] <= mem_b[1][int'(rd_addr1)];
    p1a[1] <= p1a[0];
    p1b[1] <= p1b[0];
    p1a[2] <= p1a[1];
    p1b[2] <= p1b[1];
  end

  // Expected schedule per instance and cycle.
  bit exp_busy  [0:1][0:SZ-1];
  bit exp_rd_en [0:1][0:SZ-1];
  bit exp_wr_en [0:1][0:SZ-1];
  bit exp_done  [0:1][0:SZ-1];
  bit exp_ovf   [0:1][0:SZ-1];
  int exp_rd_addr [0:1][0:SZ-1];
  int exp_wr_addr [0:1][0:SZ-1];
  int exp_wr_data [0:1][0:SZ-1];

  int checks = 0;
  int errors = 0;
  int nwr0 = 0;
  int nwr1 = 0;
  int snap;

  function automatic int fsum(int a, int b);
    int s;
    s = a + b;
`ifdef SAT_ADD_EN
    return (s > 255) ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  // Frame accepted with start high in cycle s: reads at s+1+k, writes at
  // s+2+k+l, done at s+n+2+l, busy from s+1 until the last write.
  task automatic fill_frame(int d, int s, int n, int l);
    int first_ovf;
    first_ovf = -1;
    for (int t = s + 1; t <= s + n + 1 + l; t++) exp_busy[d][t] = 1'b1;
    for (int k = 0; k < n; k++) begin
      int w;
      w = s + 2 + k + l;
      exp_rd_en[d][s+1+k]   = 1'b1;
      exp_rd_addr[d][s+1+k] = k;
      exp_wr_en[d][w]       = 1'b1;
      exp_wr_addr[d][w]     = k;
      exp_wr_data[d][w]     = fsum(int'(mem_a[d][k]), int'(mem_b[d][k]));
      if (first_ovf < 0 && int'(mem_a[d][k]) + int'(mem_b[d][k]) > 255) first_ovf = w;
    end
    exp_done[d][s+n+2+l] = 1'b1;
    for (int t = s + 1; t < SZ; t++) exp_ovf[d][t] = (first_ovf >= 0) && (t >= first_ovf);
  endtask

  task automatic clear_from(int d, int t0);
    for (int t = t0; t < SZ; t++) begin
      exp_busy[d][t]  = 1'b0;
      exp_rd_en[d][t] = 1'b0;
      exp_wr_en[d][t] = 1'b0;
      exp_done[d][t]  = 1'b0;
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic goto(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mem0(int mode);
    for (int k = 0; k < 64; k++) begin
      mem_a[0][k] = (mode == 0) ? 8'(k)     : 8'd200;
      mem_b[0][k] = (mode == 0) ? 8'(2 * k) : 8'd100;
    end
  endtask

  // Per-cycle compare against the schedule, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc < SZ) begin
        chk("busy0",  int'(busy0),  int'(exp_busy[0][cyc]));
        chk("rd_en0", int'(rd_en0), int'(exp_rd_en[0][cyc]));
        chk("wr_en0", int'(wr_en0), int'(exp_wr_en[0][cyc]));
        chk("done0",  int'(done0),  int'(exp_done[0][cyc]));
        chk("ovf0",   int'(ovf0),   int'(exp_ovf[0][cyc]));
        if (exp_rd_en[0][cyc]) chk("rd_addr0", int'(rd_addr0), exp_rd_addr[0][cyc]);
        if (exp_wr_en[0][cyc]) begin
          chk("wr_addr0", int'(wr_addr0), exp_wr_addr[0][cyc]);
          chk("wr_data0", int'(wr_data0), exp_wr_data[0][cyc]);
        end
        chk("busy1",  int'(busy1),  int'(exp_busy[1][cyc]));
        chk("rd_en1", int'(rd_en1), int'(exp_rd_en[1][cyc]));
        chk("wr_en1", int'(wr_en1), int'(exp_wr_en[1][cyc]));
        chk("done1",  int'(done1),  int'(exp_done[1][cyc]));
        chk("ovf1",   int'(ovf1),   int'(exp_ovf[1][cyc]));
        if (exp_rd_en[1][cyc]) chk("rd_addr1", int'(rd_addr1), exp_rd_addr[1][cyc]);
        if (exp_wr_en[1][cyc]) begin
          chk("wr_addr1", int'(wr_addr1), exp_wr_addr[1][cyc]);
          chk("wr_data1", int'(wr_data1), exp_wr_data[1][cyc]);
        end
        if (wr_en0) nwr0++;
        if (wr_en1) nwr1++;
      end
    end
  end

  // Directed frames with literal pins on the schedule.
  initial begin
    set_mem0(0);
    for (int k = 0; k < 64; k++) begin
      mem_a[1][k] = (k < 4) ? 8'(10 * k + 1) : 8'd0;
      mem_b[1][k] = (k < 4) ? 8'(k + 5)      : 8'd0;
    end

    goto(1);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_rd_addr", int'(rd_addr0), 0);
    chk("rst_wr_data", int'(wr_data0), 0);
    goto(3);
    reset = 1'b1;

    // Ramp frame: A=k, B=2k, second start mid-frame ignored.
    goto(10);
    start0 = 1'b1;
    fill_frame(0, 10, 64, 1);
    goto(11);
    start0 = 1'b0;
    snap = nwr0;
    goto(13);
    chk("lit_first_wr_en", int'(wr_en0), 1);
    chk("lit_first_wr_data", int'(wr_data0), 0);
    goto(20);
    start0 = 1'b1;
    goto(21);
    start0 = 1'b0;
    goto(23);
    chk("lit_k10_data", int'(wr_data0), 30);
    goto(76);
    chk("lit_last_addr", int'(wr_addr0), 63);
    chk("lit_last_data", int'(wr_data0), 189);
    goto(77);
    chk("lit_done", int'(done0), 1);
    chk("lit_done_busy", int'(busy0), 0);
    goto(78);
    chk("lit_ramp_writes", nwr0 - snap, 64);

    // Overflowing frame: A=200, B=100.
    goto(90);
    set_mem0(1);
    goto(100);
    start0 = 1'b1;
    fill_frame(0, 100, 64, 1);
    goto(101);
    start0 = 1'b0;
    goto(103);
`ifdef SAT_ADD_EN
    chk("lit_sat_data", int'(wr_data0), 255);
`else
    chk("lit_wrap_data", int'(wr_data0), 44);
`endif
    chk("lit_ovf_set", int'(ovf0), 1);

    // Small instance: 4 pixels, latency 3; start in its done cycle ignored.
    goto(200);
    start1 = 1'b1;
    fill_frame(1, 200, 4, 3);
    goto(201);
    start1 = 1'b0;
    snap = nwr1;
    goto(205);
    chk("lit_small_first_addr", int'(wr_addr1), 0);
    chk("lit_small_first_data", int'(wr_data1), 6);
    goto(208);
    chk("lit_small_last_addr", int'(wr_addr1), 3);
    chk("lit_small_last_data", int'(wr_data1), 39);
    goto(209);
    chk("lit_small_done", int'(done1), 1);
    start1 = 1'b1;
    goto(210);
    start1 = 1'b0;
    chk("lit_small_start_in_done", int'(busy1), 0);
    chk("lit_small_writes", nwr1 - snap, 4);

    // Abort on cycle 20 of an overflowing frame.
    goto(300);
    start0 = 1'b1;
    fill_frame(0, 300, 64, 1);
    goto(301);
    start0 = 1'b0;
    snap = nwr0;
    chk("lit_ovf_cleared", int'(ovf0), 0);
    goto(320);
    abort0 = 1'b1;
    clear_from(0, 321);
    for (int t = 321; t < SZ; t++) exp_ovf[0][t] = exp_ovf[0][320];
    goto(321);
    abort0 = 1'b0;
    chk("lit_abort_wr_en", int'(wr_en0), 0);
    chk("lit_abort_busy", int'(busy0), 0);
    chk("lit_abort_ovf_hold", int'(ovf0), 1);
    goto(380);
    chk("lit_abort_writes", nwr0 - snap, 18);

    // Clean frame after the abort.
    goto(390);
    set_mem0(0);
    goto(400);
    start0 = 1'b1;
    fill_frame(0, 400, 64, 1);
    goto(401);
    start0 = 1'b0;
    snap = nwr0;
    goto(467);
    chk("lit_post_abort_done", int'(done0), 1);
    goto(468);
    chk("lit_post_abort_writes", nwr0 - snap, 64);

    // Reset in the middle of a frame, then a full frame.
    goto(490);
    set_mem0(1);
    goto(500);
    start0 = 1'b1;
    fill_frame(0, 500, 64, 1);
    goto(501);
    start0 = 1'b0;
    goto(530);
    for (int d = 0; d < 2; d++) begin
      clear_from(d, 530);
      for (int t = 530; t < SZ; t++) exp_ovf[d][t] = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("lit_rst_rd_en", int'(rd_en0), 0);
    chk("lit_rst_rd_addr", int'(rd_addr0), 0);
    chk("lit_rst_wr_en", int'(wr_en0), 0);
    chk("lit_rst_wr_addr", int'(wr_addr0), 0);
    chk("lit_rst_wr_data", int'(wr_data0), 0);
    chk("lit_rst_busy", int'(busy0), 0);
    chk("lit_rst_ovf", int'(ovf0), 0);
    goto(532);
    reset = 1'b1;
    set_mem0(0);
    goto(540);
    start0 = 1'b1;
    fill_frame(0, 540, 64, 1);
    goto(541);
    start0 = 1'b0;
    snap = nwr0;
    goto(607);
    chk("lit_post_rst_done", int'(done0), 1);
    chk("lit_post_rst_ovf", int'(ovf0), 0);
    goto(608);
    chk("lit_post_rst_writes", nwr0 - snap, 64);

    goto(620);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
